array_shift_down: RTL
=====================

Name: array_shift_down

Overview:
- Removal engine for fixed-area heap arrays: the inverse of the shift-up/insert operation.
- Owns a heap of NArrays areas of NArea elements each, plus a per-array size table.
- On command it removes the element at position `pos` of array `array`, returns the removed value, and moves every higher element down one slot, one element per clock.
- Decrements the array size. Sits beside the program executor as the shiftDown/pop-at-index unit.

Parameters:
- MemoryElementWidth, 12, element and size width in bits.
- NArea, 4, elements per array area. Heap address = NArea*array + index.
- NArrays, 2, number of array areas.
- IW, $clog2(NArea), index width.
- AW, $clog2(NArrays) (minimum 1), array-number width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a shift-down; accepted only when busy=0
- array  in  AW  target array, sampled with start
- pos  in  IW  index to remove, sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done: bad array/pos, no state changed
- removed  out  MemoryElementWidth  removed value, valid with done, held until the next done
- wr_en  in  1  element write, honoured only when busy=0
- wr_array  in  AW  element write array
- wr_index  in  IW  element write index
- wr_data  in  MemoryElementWidth  element write value
- sz_en  in  1  size write, honoured only when busy=0 and wr_en=0
- sz_array  in  AW  size write array
- sz_value  in  MemoryElementWidth  new size, clamped to NArea
- rd_array  in  AW  combinational read port, array
- rd_index  in  IW  combinational read port, index
- rd_data  out  MemoryElementWidth  heap[NArea*rd_array + rd_index]
- rd_size  out  MemoryElementWidth  size of rd_array

Behaviour:
- Reset (async, reset_n=0):
  - all heap elements = 0, all sizes = 0, state = IDLE.
  - busy = 0, done = 0, error = 0, removed = 0.
  - An in-flight operation is abandoned. Partially shifted data stays as left; after reset it is 0 anyway.
- Element write (wr_en):
  - heap[wr_array][wr_index] = wr_data.
  - if size < wr_index+1, size = wr_index+1.
- State IDLE, start=1:
  - latch array and pos; busy=1; next state CHECK.
  - start has priority over a same-cycle wr_en/sz_en, which is dropped.
- State CHECK:
  - If array >= NArrays or pos >= size[array] (including size=0): done=1 and error=1 for one cycle; busy=0; back to IDLE. Heap, sizes and removed are unchanged.
  - Otherwise: removed = heap[array][pos]; idx = pos; next state SHIFT.
- State SHIFT:
  - If idx+1 < size: heap[idx] = heap[idx+1]; idx++. One element per cycle.
  - Else go to FINISH.
- State FINISH:
  - size = size-1; done=1, error=0; busy=0; back to IDLE.
- Latency: for size n and valid pos p, done is visible n-p+1 clocks after the start edge. Examples: p=n-1 gives 2 clocks; n=4, p=0 gives 5 clocks.
- start while busy=1 is ignored, with no queueing. start in the same cycle that done is asserted is accepted, since state is already IDLE.
- All index arithmetic is unsigned, IW+1 bits; sizes never underflow.
- The read port is always live and reflects the heap mid-shift.

Optional Feature:
- Macro: ARRAY_SHIFT_DOWN_CLEAR_EN.
- Defined: FINISH also writes 0 to heap[array][n-1], the vacated top slot.
- Undefined: the vacated slot keeps its stale value, a duplicate of the old last element. Sizes and latency are identical either way.

Decomposition:
- Package array_pkg:
  - MemoryElementWidth, NArea, NArrays defaults.
  - state enum: IDLE, CHECK, SHIFT, FINISH.
  - heap address function arrayAddr(array, index) = NArea*array + index.
- One natural sub-module, array_heap_store: heap and size-table registers, write and size ports, combinational read. Shared with the shift-up block.
- The FSM stays in array_shift_down.

Test Plan:
- Load array 1 = {0,1,99,2}, size 4; start pos=2 -> done after 3 clocks, removed=99, error=0, array 1 = {0,1,2,x}, rd_size=3. With CLEAR_EN, x=0; without it, x=2.
- Same load, pos=0 -> done after 5 clocks, removed=0, array 1 = {1,99,2}, size 3. Array 0 is untouched.
- Array 1 size 3, pos=3 -> done+error after 2 clocks, removed holds its prior value, heap and size unchanged. An empty array with pos=0 gives the same result.
- Start pos=0 on size 4; assert start again plus wr_en mid-operation -> both ignored; single done at clock 5.
- Start pos=0 on size 4; pull reset_n low at clock 3 -> busy, done and error are 0 immediately; all sizes and elements read 0.
- Pop pos=0 four times in succession, restarting on each done, from {0,1,99,2} -> removed sequence 0,1,99,2; size ends at 0; a fifth pop returns error.

Source files
------------

// File: rtl/array_pkg.sv
// Shared geometry, FSM state type and heap address helper for the array engines.
package array_pkg;

    localparam int unsigned MemoryElementWidth = 12;
    localparam int unsigned NArea              = 4;
    localparam int unsigned NArrays            = 2;
    localparam int unsigned IW  = (NArea > 1) ? $clog2(NArea) : 1;
    localparam int unsigned AW  = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int unsigned HAW = (NArrays * NArea > 1) ? $clog2(NArrays * NArea) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        FINISH
    } state_t;

    function automatic logic [HAW-1:0] arrayAddr(input logic [AW-1:0] array,
                                                 input logic [IW-1:0] index);
        return HAW'(NArea * 32'(array) + 32'(index));
    endfunction

endpackage

// File: rtl/array_heap_store.sv
// Heap element and per-array size registers with external write/size ports,
// an engine port (move-down, clear, size decrement) and combinational reads.
module array_heap_store
    import array_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_array,
    input  logic [IW-1:0]                 wr_index,
    input  logic [MemoryElementWidth-1:0] wr_data,
    input  logic                          sz_en,
    input  logic [AW-1:0]                 sz_array,
    input  logic [MemoryElementWidth-1:0] sz_value,
    input  logic [AW-1:0]                 op_array,
    input  logic [IW-1:0]                 op_index,
    input  logic                          op_move,
    input  logic                          op_clear,
    input  logic [IW-1:0]                 op_top,
    input  logic                          op_dec,
    output logic [MemoryElementWidth-1:0] op_data,
    output logic [MemoryElementWidth-1:0] op_size,
    input  logic [AW-1:0]                 rd_array,
    input  logic [IW-1:0]                 rd_index,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [MemoryElementWidth-1:0] rd_size
);

    localparam int unsigned W     = MemoryElementWidth;
    localparam int unsigned Depth = NArrays * NArea;

    logic [W-1:0]   heap  [Depth];
    logic [W-1:0]   sizes [NArrays];
    logic [HAW-1:0] op_addr;

    assign op_addr = arrayAddr(op_array, op_index);

    // External writes and engine updates never overlap: the engine gates them by busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(Depth); i++) heap[HAW'(i)] <= '0;
            for (int a = 0; a < int'(NArrays); a++) sizes[AW'(a)] <= '0;
        end else begin
            if (wr_en) begin
                heap[arrayAddr(wr_array, wr_index)] <= wr_data;
                if (sizes[wr_array] < W'(wr_index) + W'(1))
                    sizes[wr_array] <= W'(wr_index) + W'(1);
            end
            if (sz_en)
                sizes[sz_array] <= (sz_value > W'(NArea)) ? W'(NArea) : sz_value;
            if (op_move)
                heap[op_addr] <= heap[op_addr + HAW'(1)];
            if (op_clear)
                heap[arrayAddr(op_array, op_top)] <= '0;
            if (op_dec && sizes[op_array] != '0)
                sizes[op_array] <= sizes[op_array] - W'(1);
        end
    end

    assign op_data = heap[op_addr];
    assign op_size = (32'(op_array) < NArrays) ? sizes[op_array] : '0;
    assign rd_data = (32'(rd_array) < NArrays) ? heap[arrayAddr(rd_array, rd_index)] : '0;
    assign rd_size = (32'(rd_array) < NArrays) ? sizes[rd_array] : '0;

endmodule

// File: rtl/array_shift_down.sv
// Pop-at-index engine: removes heap[array][pos], shifts higher elements down one per clock.
// Define ARRAY_SHIFT_DOWN_CLEAR_EN to zero the vacated top slot on completion.
module array_shift_down
    import array_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [AW-1:0]                 array,
    input  logic [IW-1:0]                 pos,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] removed,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_array,
    input  logic [IW-1:0]                 wr_index,
    input  logic [MemoryElementWidth-1:0] wr_data,
    input  logic                          sz_en,
    input  logic [AW-1:0]                 sz_array,
    input  logic [MemoryElementWidth-1:0] sz_value,
    input  logic [AW-1:0]                 rd_array,
    input  logic [IW-1:0]                 rd_index,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [MemoryElementWidth-1:0] rd_size
);

    localparam int unsigned W = MemoryElementWidth;

    state_t        state, state_nx;
    logic [AW-1:0] op_array, op_array_nx;
    logic [IW:0]   idx, idx_nx, idx_p1, idx_p2;
    logic          busy_nx, done_nx, error_nx;
    logic [W-1:0]  removed_nx;
    logic          move_c, clear_c, finish_c, ext_wr_c, ext_sz_c;
    logic [W-1:0]  op_data, op_size;
    logic [IW-1:0] op_top;

    assign idx_p1   = idx + (IW+1)'(1);
    assign idx_p2   = idx + (IW+1)'(2);
    assign op_top   = IW'(op_size - W'(1));
    assign ext_wr_c = wr_en && !busy && !start;
    assign ext_sz_c = sz_en && !busy && !start && !wr_en;

`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
    assign clear_c = finish_c;
`else
    assign clear_c = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_array <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            removed  <= '0;
        end else begin
            state    <= state_nx;
            op_array <= op_array_nx;
            idx      <= idx_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            error    <= error_nx;
            removed  <= removed_nx;
        end
    end

    // The last move, size decrement and top clear share one edge; FINISH is the
    // done cycle and behaves as idle, so a new start is accepted there.
    always_comb begin
        state_nx    = state;
        op_array_nx = op_array;
        idx_nx      = idx;
        busy_nx     = busy;
        done_nx     = 1'b0;
        error_nx    = 1'b0;
        removed_nx  = removed;
        move_c      = 1'b0;
        finish_c    = 1'b0;
        case (state)
            IDLE, FINISH: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
                if (start) begin
                    op_array_nx = array;
                    idx_nx      = {1'b0, pos};
                    busy_nx     = 1'b1;
                    state_nx    = CHECK;
                end
            end
            CHECK: begin
                if (32'(op_array) >= NArrays || W'(idx) >= op_size) begin
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    removed_nx = op_data;
                    if (W'(idx_p1) < op_size) state_nx = SHIFT;
                    else                      finish_c = 1'b1;
                end
            end
            SHIFT: begin
                move_c = 1'b1;
                idx_nx = idx_p1;
                if (W'(idx_p2) >= op_size) finish_c = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (finish_c) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = FINISH;
        end
    end

    array_heap_store u_store (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (ext_wr_c),
        .wr_array (wr_array),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .sz_en    (ext_sz_c),
        .sz_array (sz_array),
        .sz_value (sz_value),
        .op_array (op_array),
        .op_index (idx[IW-1:0]),
        .op_move  (move_c),
        .op_clear (clear_c),
        .op_top   (op_top),
        .op_dec   (finish_c),
        .op_data  (op_data),
        .op_size  (op_size),
        .rd_array (rd_array),
        .rd_index (rd_index),
        .rd_data  (rd_data),
        .rd_size  (rd_size)
    );

endmodule
